dataflow_rr_arbiter: RTL and testbench

Two-requester round-robin arbiter with a single registered output slot and taint tracking in the style of the data-flow tests. Two producers share one output channel: each presents a request bit and a WIDTH-bit word, and the block grants one per accepted transfer and buffers the winning word in a one-entry output register with a valid/ready handshake. Every data and control signal has a `_t0` taint shadow. Taint on the request bits or on the priority state is treated as control-flow taint, which fully taints the selected output word.

---
 rtl/dataflow_rr_arbiter.sv | 78 +++++++
 tb/tb_dataflow_rr_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dataflow_rr_arbiter.sv
// rtl/dataflow_rr_arbiter.sv - two-requester round-robin arbiter with one-entry output slot and taint shadows
module dataflow_rr_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c1,
  input  logic [WIDTH-1:0] d1,
  input  logic             c2,
  input  logic [WIDTH-1:0] d2,
  input  logic             c1_t0,
  input  logic             c2_t0,
  input  logic [WIDTH-1:0] d1_t0,
  input  logic [WIDTH-1:0] d2_t0,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_t0,
  output logic             out_valid_t0,
  output logic             grant1,
  output logic             grant2,
  output logic             grant1_t0,
  output logic             grant2_t0
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_t0_q;
  logic             vld_q;
  logic             vld_t0_q;
  logic             prio;
  logic             prio_t0;

  logic free;
  logic load;
  logic win2;
  logic ctrl_t;

  assign free = ~vld_q | out_ready;
  assign load = free & (c1 | c2);
  // requester 2 wins when it is alone, or when both ask and it holds priority
  assign win2 = c2 & (~c1 | prio);
  // priority taint only matters when the choice actually depended on prio
  assign ctrl_t = c1_t0 | c2_t0 | (prio_t0 & c1 & c2);

  assign grant1    = ~rst & load & ~win2;
  assign grant2    = ~rst & load & win2;
  assign grant1_t0 = ~rst & free & ctrl_t;
  assign grant2_t0 = ~rst & free & ctrl_t;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      out_t0_q <= '0;
      vld_q    <= 1'b0;
      vld_t0_q <= 1'b0;
      prio     <= 1'b0;
      prio_t0  <= 1'b0;
    end else if (free) begin
      if (load) begin
        out_q    <= win2 ? d2 : d1;
        out_t0_q <= (win2 ? d2_t0 : d1_t0) | {WIDTH{ctrl_t}};
        vld_q    <= 1'b1;
        vld_t0_q <= ctrl_t;
        prio     <= ~win2;
        prio_t0  <= prio_t0 | ctrl_t;
      end else begin
        vld_q    <= 1'b0;
        vld_t0_q <= 1'b0;
      end
    end
  end

  assign out          = out_q;
  assign out_valid    = vld_q;
  assign out_t0       = out_t0_q;
  assign out_valid_t0 = vld_t0_q;

endmodule

// File: tb/tb_dataflow_rr_arbiter.sv
// tb/tb_dataflow_rr_arbiter.sv - directed self-checking bench for dataflow_rr_arbiter
module tb_dataflow_rr_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             c1, c2, c1_t0, c2_t0;
  logic [WIDTH-1:0] d1, d2, d1_t0, d2_t0;
  logic             out_ready;
  logic [WIDTH-1:0] out, out_t0;
  logic             out_valid, out_valid_t0;
  logic             grant1, grant2, grant1_t0, grant2_t0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dataflow_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .c1(c1), .d1(d1), .c2(c2), .d2(d2),
    .c1_t0(c1_t0), .c2_t0(c2_t0), .d1_t0(d1_t0), .d2_t0(d2_t0),
    .out_ready(out_ready),
    .out(out), .out_valid(out_valid), .out_t0(out_t0), .out_valid_t0(out_valid_t0),
    .grant1(grant1), .grant2(grant2), .grant1_t0(grant1_t0), .grant2_t0(grant2_t0)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [WIDTH-1:0] e_out, input logic e_vld,
                            input logic [WIDTH-1:0] e_t0, input logic e_vt0);
    check_eq({tag, ".out"}, 64'(out), 64'(e_out));
    check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(e_vld));
    check_eq({tag, ".out_t0"}, 64'(out_t0), 64'(e_t0));
    check_eq({tag, ".out_valid_t0"}, 64'(out_valid_t0), 64'(e_vt0));
  endtask

  task automatic check_grants(input string tag, input logic e_g1, input logic e_g2, input logic e_gt);
    check_eq({tag, ".grant1"}, 64'(grant1), 64'(e_g1));
    check_eq({tag, ".grant2"}, 64'(grant2), 64'(e_g2));
    check_eq({tag, ".grant1_t0"}, 64'(grant1_t0), 64'(e_gt));
    check_eq({tag, ".grant2_t0"}, 64'(grant2_t0), 64'(e_gt));
  endtask

  logic [WIDTH-1:0] alt_d [4];
  logic             alt_g2 [4];

  initial begin
    rst = 1'b1; c1 = 1'b0; c2 = 1'b0; c1_t0 = 1'b0; c2_t0 = 1'b0;
    d1 = '0; d2 = '0; d1_t0 = '0; d2_t0 = '0; out_ready = 1'b1;

    // reset: a held request must not be granted while rst=1
    tick();
    c1 = 1'b1; #1;
    check_grants("rst_gate", 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("rst", '0, 1'b0, '0, 1'b0);
    c1 = 1'b0; rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_grants("idle", 1'b0, 1'b0, 1'b0);
      tick();
      check_outs("idle", '0, 1'b0, '0, 1'b0);
    end

    // single requester, then slot drains and holds the word
    c1 = 1'b1; d1 = 32'hdeadbeef; #1;
    check_grants("single", 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("single", 32'hdeadbeef, 1'b1, '0, 1'b0);
    c1 = 1'b0; #1;
    check_grants("drain", 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("drain", 32'hdeadbeef, 1'b0, '0, 1'b0);

    // prio is now 1 (requester 2 preferred); reset to restart from prio 0
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // alternation with back-to-back pop and load
    alt_d[0] = 32'd1; alt_d[1] = 32'd2; alt_d[2] = 32'd1; alt_d[3] = 32'd2;
    alt_g2[0] = 1'b0; alt_g2[1] = 1'b1; alt_g2[2] = 1'b0; alt_g2[3] = 1'b1;
    c1 = 1'b1; c2 = 1'b1; d1 = 32'd1; d2 = 32'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_grants("alt", ~alt_g2[i], alt_g2[i], 1'b0);
      tick();
      check_outs("alt", alt_d[i], 1'b1, '0, 1'b0);
    end

    // backpressure: slot full, out_ready low, c2 waiting
    c1 = 1'b0; d2 = 32'h0000abcd; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_grants("stall", 1'b0, 1'b0, 1'b0);
      tick();
      check_outs("stall", 32'd2, 1'b1, '0, 1'b0);
    end
    out_ready = 1'b1; #1;
    check_grants("release", 1'b0, 1'b1, 1'b0);
    tick();
    check_outs("release", 32'h0000abcd, 1'b1, '0, 1'b0);
    c2 = 1'b0;

    // data taint only
    c1 = 1'b1; d1 = 32'h5; d1_t0 = 32'hffffffff; #1;
    check_grants("dtaint", 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("dtaint", 32'h5, 1'b1, 32'hffffffff, 1'b0);

    // control taint on request 2 taints requester 1's word
    d1 = 32'h6; d1_t0 = '0; c2_t0 = 1'b1; #1;
    check_grants("ctaint", 1'b1, 1'b0, 1'b1);
    tick();
    check_outs("ctaint", 32'h6, 1'b1, 32'hffffffff, 1'b1);

    // sticky prio taint: lone request ignores prio, so stays clean
    c2_t0 = 1'b0; d1 = 32'h7; #1;
    check_grants("lone_clean", 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("lone_clean", 32'h7, 1'b1, '0, 1'b0);

    // both requesting: choice depends on tainted prio (prio=1 -> req 2)
    c2 = 1'b1; d2 = 32'h8; #1;
    check_grants("prio_t", 1'b0, 1'b1, 1'b1);
    tick();
    check_outs("prio_t", 32'h8, 1'b1, 32'hffffffff, 1'b1);

    // reset mid-operation with c1 still held
    rst = 1'b1; c2 = 1'b0; #1;
    check_grants("rst_mid", 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("rst_mid", '0, 1'b0, '0, 1'b0);
    rst = 1'b0; d1 = 32'h9; #1;
    check_grants("rearb", 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("rearb", 32'h9, 1'b1, '0, 1'b0);

    // prio_t0 cleared by reset: contested load is clean, and alternates to req 2
    c2 = 1'b1; d2 = 32'ha; #1;
    check_grants("post_rst", 1'b0, 1'b1, 1'b0);
    tick();
    check_outs("post_rst", 32'ha, 1'b1, '0, 1'b0);
    c1 = 1'b0; c2 = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
